lsu_dbus: RTL
=============

Name: lsu_dbus

Overview:
Load/store unit in the MEM stage of the Buceros core. It receives the memory command the ID/EX register hands to EX (rmem/wmem enable, funct3, computed address, store data, writeback target) and runs a req/gnt/rvalid handshake with the data bus. It produces aligned loads with sign/zero extension, byte-lane stores, a pipeline stall request while an access is outstanding, and error pulses for misaligned, illegal or timed-out accesses.

Parameters:
ADDR_W, 32, address width.
DATA_W, 32, bus and register data width (fixed 32; other values unsupported).
REG_ADDR_W, 5, register index width.
TIMEOUT, 16, cycles allowed in REQ+WAIT before abort; 0 disables the timeout.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  reset, asynchronous, active-low.
ex_rmem_en_i  in  1  load command.
ex_wmem_en_i  in  1  store command.
ex_funct3_i  in  3  access size/sign.
ex_addr_i  in  ADDR_W  byte address.
ex_wdata_i  in  DATA_W  store data (rs2).
ex_wreg_en_i  in  1  load writes a register.
ex_wreg_addr_i  in  REG_ADDR_W  load destination.
dbus_req_o  out  1  bus request.
dbus_we_o  out  1  1 = write.
dbus_addr_o  out  ADDR_W  word address ({addr[ADDR_W-1:2],2'b00}).
dbus_be_o  out  4  byte enables.
dbus_wdata_o  out  DATA_W  lane-replicated store data.
dbus_gnt_i  in  1  request accepted.
dbus_rvalid_i  in  1  read data valid.
dbus_rdata_i  in  DATA_W  read data.
mem_wreg_en_o  out  1  load result valid (1-cycle pulse).
mem_wreg_addr_o  out  REG_ADDR_W  load destination.
mem_wreg_data_o  out  DATA_W  extended load result.
stallreq_lsu_o  out  1  hold the pipeline.
err_o  out  1  error pulse.
err_cause_o  out  2  01 misaligned, 10 illegal, 11 timeout; 00 when err_o=0.

Behaviour:
- Reset: state IDLE, timeout counter 0; every output 0 (combinational outputs evaluate to 0 in IDLE with no command).
- A legal command is exactly one of rmem/wmem set, with funct3 in {000,001,010,100,101} for loads or {000,001,010} for stores. Any other combination, including both enables set, is illegal.
- Alignment: halfword needs addr[0]=0; word needs addr[1:0]=00.
- Illegal or misaligned command in IDLE: no bus request, no stall. Next cycle err_o=1 for one cycle with the matching cause. Illegal takes precedence over misaligned.
- FSM states IDLE, REQ, WAIT.
- IDLE with a legal command: dbus_req_o=1 combinationally, with addr/be/wdata/we driven from the inputs. The inputs stay stable because the stall holds the pipeline.
  - gnt=0 -> REQ.
  - Load with gnt=1 -> WAIT.
  - Store with gnt=1 -> store done, stay IDLE.
- REQ: req held with unchanged addr/be/we/wdata until gnt. On gnt, a load goes to WAIT and a store completes -> IDLE. rvalid in REQ is ignored.
- WAIT: req=0. On rvalid -> IDLE. The load result is registered, so mem_wreg_en_o (= latched wreg_en), mem_wreg_addr_o and mem_wreg_data_o are valid the cycle after rvalid for exactly one cycle.
- rvalid is never accepted in the gnt cycle; the earliest is gnt+1. rvalid in IDLE (stale) is ignored.
- Latched at the request edge: addr[1:0], funct3, wreg_en, wreg_addr.
- stallreq_lsu_o = legal command in IDLE and not completing this cycle, OR state REQ and not (store & gnt), OR state WAIT and not rvalid. It drops in the completion cycle, so the pipeline advances at that edge. A store granted immediately costs 0 stall cycles; a load with gnt at c0 and rvalid at c1 stalls 1 cycle.
- Store lanes:
  - SB: be=4'b0001<<addr[1:0], wdata={4{byte}}.
  - SH: be = addr[1] ? 1100 : 0011, wdata={2{half}}.
  - SW: be=1111.
- Load extraction: rdata>>(8*off), then LB/LH sign-extend and LBU/LHU zero-extend. Loads drive be per the same lane rule.
- Timeout: counter clears on entering REQ/WAIT and increments each cycle there. If it reaches TIMEOUT without completion:
  - req=0, state -> IDLE, stall drops in that cycle;
  - next cycle err_o=1, cause 11;
  - no writeback.
- Asynchronous reset mid-access aborts it; no writeback and no error. Later gnt/rvalid are ignored.
- New command in the cycle after completion (the next instruction) is accepted normally, giving back-to-back accesses.

Test Plan:
- LW addr 0x100, gnt at c0, rvalid at c1 with rdata 0xDEADBEEF -> req only at c0, be=1111, stall high c0 only; c2 wreg_en=1, data 0xDEADBEEF, rd as given.
- LB addr 0x103 with rdata 0x80112233, then LBU same -> 0xFFFFFF80, then 0x00000080; LH addr 0x102 -> 0xFFFF8011.
- SH addr 0x202 data 0x0000ABCD, gnt delayed 3 cycles -> req/addr 0x200/be 1100/wdata 0xABCDABCD stable 4 cycles, stall high 3 cycles, no writeback.
- LW addr 0x101 -> no req, no stall, err_o pulse cause 01; wmem+rmem both set -> cause 10.
- TIMEOUT=4, load granted but no rvalid -> stall drops after 4 cycles in REQ/WAIT, err cause 11, later rvalid ignored, no writeback.
- Reset asserted in WAIT -> all outputs 0 immediately; rvalid after release -> no writeback.

Source files
------------

// File: rtl/lsu_dbus.sv
// MEM-stage load/store unit: req/gnt/rvalid data-bus handshake, lane steering,
// load extension, pipeline stall and misaligned/illegal/timeout error pulses.
module lsu_dbus #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ex_rmem_en_i,
  input  logic                  ex_wmem_en_i,
  input  logic [2:0]            ex_funct3_i,
  input  logic [ADDR_W-1:0]     ex_addr_i,
  input  logic [DATA_W-1:0]     ex_wdata_i,
  input  logic                  ex_wreg_en_i,
  input  logic [REG_ADDR_W-1:0] ex_wreg_addr_i,
  output logic                  dbus_req_o,
  output logic                  dbus_we_o,
  output logic [ADDR_W-1:0]     dbus_addr_o,
  output logic [3:0]            dbus_be_o,
  output logic [DATA_W-1:0]     dbus_wdata_o,
  input  logic                  dbus_gnt_i,
  input  logic                  dbus_rvalid_i,
  input  logic [DATA_W-1:0]     dbus_rdata_i,
  output logic                  mem_wreg_en_o,
  output logic [REG_ADDR_W-1:0] mem_wreg_addr_o,
  output logic [DATA_W-1:0]     mem_wreg_data_o,
  output logic                  stallreq_lsu_o,
  output logic                  err_o,
  output logic [1:0]            err_cause_o
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q;
  logic                    tmo;

  // request context captured at the request edge
  logic                    we_q;
  logic [ADDR_W-1:0]       addr_q;
  logic [3:0]              be_q;
  logic [DATA_W-1:0]       wdata_q;
  logic [1:0]              off_q;
  logic [2:0]              f3_q;
  logic                    wen_q;
  logic [REG_ADDR_W-1:0]   wa_q;

  logic                    cmd_any, legal, aligned, cmd_ok, latch, done_ld;
  logic [3:0]              be_in;
  logic [DATA_W-1:0]       wdata_in, shifted, ld_data;
  logic [1:0]              err_d;

  always_comb begin
    cmd_any = rst_n & (ex_rmem_en_i | ex_wmem_en_i);
    legal   = 1'b0;
    if (ex_rmem_en_i ^ ex_wmem_en_i) begin
      case (ex_funct3_i)
        3'b000, 3'b001, 3'b010: legal = 1'b1;
        3'b100, 3'b101:         legal = ex_rmem_en_i;
        default:                legal = 1'b0;
      endcase
    end
    case (ex_funct3_i[1:0])
      2'b01:   aligned = ~ex_addr_i[0];
      2'b10:   aligned = (ex_addr_i[1:0] == 2'b00);
      default: aligned = 1'b1;
    endcase
    case (ex_funct3_i[1:0])
      2'b00: begin
        be_in    = 4'b0001 << ex_addr_i[1:0];
        wdata_in = {4{ex_wdata_i[7:0]}};
      end
      2'b01: begin
        be_in    = ex_addr_i[1] ? 4'b1100 : 4'b0011;
        wdata_in = {2{ex_wdata_i[15:0]}};
      end
      default: begin
        be_in    = 4'b1111;
        wdata_in = ex_wdata_i;
      end
    endcase
    cmd_ok = cmd_any & legal & aligned;
  end

  assign tmo = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT));

  always_comb begin
    state_d        = state_q;
    dbus_req_o     = 1'b0;
    dbus_we_o      = 1'b0;
    dbus_addr_o    = '0;
    dbus_be_o      = '0;
    dbus_wdata_o   = '0;
    stallreq_lsu_o = 1'b0;
    latch          = 1'b0;
    done_ld        = 1'b0;
    err_d          = 2'b00;
    case (state_q)
      IDLE: begin
        if (cmd_ok) begin
          dbus_req_o     = 1'b1;
          dbus_we_o      = ex_wmem_en_i;
          dbus_addr_o    = {ex_addr_i[ADDR_W-1:2], 2'b00};
          dbus_be_o      = be_in;
          dbus_wdata_o   = wdata_in;
          stallreq_lsu_o = ~(ex_wmem_en_i & dbus_gnt_i);
          latch          = 1'b1;
          if (!dbus_gnt_i)        state_d = REQ;
          else if (!ex_wmem_en_i) state_d = WAIT;
        end else if (cmd_any) begin
          err_d = legal ? 2'b01 : 2'b10;
        end
      end
      REQ: begin
        if (tmo) begin
          state_d = IDLE;
          err_d   = 2'b11;
        end else begin
          dbus_req_o     = 1'b1;
          dbus_we_o      = we_q;
          dbus_addr_o    = addr_q;
          dbus_be_o      = be_q;
          dbus_wdata_o   = wdata_q;
          stallreq_lsu_o = ~(we_q & dbus_gnt_i);
          if (dbus_gnt_i) state_d = we_q ? IDLE : WAIT;
        end
      end
      WAIT: begin
        // a response arriving on the deadline cycle still completes the load
        if (dbus_rvalid_i) begin
          state_d = IDLE;
          done_ld = 1'b1;
        end else if (tmo) begin
          state_d = IDLE;
          err_d   = 2'b11;
        end else begin
          stallreq_lsu_o = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    shifted = dbus_rdata_i >> {off_q, 3'b000};
    case (f3_q)
      3'b000:  ld_data = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  ld_data = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  ld_data = {24'b0, shifted[7:0]};
      3'b101:  ld_data = {16'b0, shifted[15:0]};
      default: ld_data = shifted;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      we_q            <= 1'b0;
      addr_q          <= '0;
      be_q            <= '0;
      wdata_q         <= '0;
      off_q           <= '0;
      f3_q            <= '0;
      wen_q           <= 1'b0;
      wa_q            <= '0;
      mem_wreg_en_o   <= 1'b0;
      mem_wreg_addr_o <= '0;
      mem_wreg_data_o <= '0;
      err_o           <= 1'b0;
      err_cause_o     <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q   <= (state_q == IDLE) ? '0 : cnt_q + CNT_W'(1);
      if (latch) begin
        we_q    <= ex_wmem_en_i;
        addr_q  <= {ex_addr_i[ADDR_W-1:2], 2'b00};
        be_q    <= be_in;
        wdata_q <= wdata_in;
        off_q   <= ex_addr_i[1:0];
        f3_q    <= ex_funct3_i;
        wen_q   <= ex_wreg_en_i;
        wa_q    <= ex_wreg_addr_i;
      end
      mem_wreg_en_o   <= done_ld & wen_q;
      mem_wreg_addr_o <= done_ld ? wa_q : '0;
      mem_wreg_data_o <= done_ld ? ld_data : '0;
      err_o           <= |err_d;
      err_cause_o     <= err_d;
    end
  end

endmodule
